// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
//   Sequencer and round-key store placed in front of an AES-128 key expansion
//   stage. A start request loads the cipher key into the stage through its
//   bypass path. The controller then steps the stage through rounds 1..10,
//   feeding each registered stage output back in as the next input. Every
//   round key is captured into an 11 x 128 store. The store can afterwards be
//   read by round index in any order, for example in reverse for decryption.
//
// Ports
//   clk         in   1    clock, rising edge
//   rst         in   1    synchronous reset, active-high
//   start       in   1    begin a schedule for cipher_key (only honoured in IDLE/DONE)
//   cipher_key  in   128  initial key, byte K0 = [127:120] ... K15 = [7:0]
//   ke_key_out  in   128  registered output of the expansion stage
//   ke_key_in   out  128  input to the expansion stage (combinational mux)
//   ke_round    out  4    round number to the expansion stage
//   ke_bypass   out  1    bypass control to the expansion stage
//   ke_enable   out  1    expansion enable to the expansion stage
//   busy        out  1    schedule generation in progress
//   keys_ready  out  1    all round keys are valid in the store
//   rd_en       in   1    read request
//   rd_round    in   4    round index to read, 0..10
//   rd_valid    out  1    rd_key valid, one-cycle pulse
//   rd_key      out  128  round key read from the store
//   rd_err      out  1    one-cycle pulse for an out-of-range or not-ready read

module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic [127:0] ke_key_out,
  output logic [127:0] ke_key_in,
  output logic [3:0]   ke_round,
  output logic         ke_bypass,
  output logic         ke_enable,
  output logic         busy,
  output logic         keys_ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    FINAL,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] store_q [0:NUM_ROUNDS];
  logic         rd_valid_q, rd_err_q;
  logic [127:0] rd_key_q;

  // State register and round step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state logic. The round counter only advances while expanding.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        state_d = EXPAND;
        round_d = 4'd1;
      end
      EXPAND: begin
        if (round_q == LastRound) begin
          state_d = FINAL;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      FINAL: begin
        state_d = DONE;
      end
      DONE: begin
        if (start) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Output decode. Outside LOAD/EXPAND the stage sees its own output with
  // enable and bypass low, so it simply holds its value.
  always_comb begin
    ke_key_in  = ke_key_out;
    ke_round   = 4'd0;
    ke_bypass  = 1'b0;
    ke_enable  = 1'b0;
    busy       = 1'b0;
    keys_ready = 1'b0;
    unique case (state_q)
      LOAD: begin
        ke_key_in = cipher_key;
        ke_bypass = 1'b1;
        busy      = 1'b1;
      end
      EXPAND: begin
        ke_enable = 1'b1;
        ke_round  = round_q;
        busy      = 1'b1;
      end
      FINAL: begin
        busy = 1'b1;
      end
      DONE: begin
        keys_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Key capture. The stage output lags the round number by one edge, so in
  // EXPAND round r it still shows key r-1, and in FINAL it shows the last key.
  // The store has no reset; keys_ready gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == EXPAND) begin
        store_q[round_q - 4'd1] <= ke_key_out;
      end else if (state_q == FINAL) begin
        store_q[LastRound] <= ke_key_out;
      end
    end
  end

  // Registered read port. A read that coincides with a restart still sees
  // keys_ready high and therefore returns the previous key set.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_key_q   <= '0;
    end else if (rd_en) begin
      if (keys_ready && (rd_round <= LastRound)) begin
        rd_valid_q <= 1'b1;
        rd_err_q   <= 1'b0;
        rd_key_q   <= store_q[rd_round];
      end else begin
        rd_valid_q <= 1'b0;
        rd_err_q   <= 1'b1;
        rd_key_q   <= '0;
      end
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_key   = rd_key_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl
//   Bench for key_schedule_ctrl. It contains a behavioural AES-128 expansion
//   stage wired to the controller, a cycle-level expectation of the controller
//   outputs, and directed scenarios with literal FIPS-197 round keys.

module tb_key_schedule_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipherKey = '0;
  logic [127:0] keKeyOut;
  logic [127:0] keKeyIn;
  logic [3:0]   keRound;
  logic         keBypass;
  logic         keEnable;
  logic         busy;
  logic         keysReady;
  logic         rdEn = 1'b0;
  logic [3:0]   rdRound = 4'd0;
  logic         rdValid;
  logic [127:0] rdKey;
  logic         rdErr;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  localparam logic [127:0] FipsKey   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SeqKey    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SeqR10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clock = ~clock;

  key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk        (clock),
    .rst        (reset),
    .start      (start),
    .cipher_key (cipherKey),
    .ke_key_out (keKeyOut),
    .ke_key_in  (keKeyIn),
    .ke_round   (keRound),
    .ke_bypass  (keBypass),
    .ke_enable  (keEnable),
    .busy       (busy),
    .keys_ready (keysReady),
    .rd_en      (rdEn),
    .rd_round   (rdRound),
    .rd_valid   (rdValid),
    .rd_key     (rdKey),
    .rd_err     (rdErr)
  );

  // GF(2^8) arithmetic for the AES S-box, computed rather than tabulated.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h01;
    for (int j = 1; j < int'(r); j++) v = gmul(v, 8'h02);
    return v;
  endfunction

  // One AES-128 key expansion step from the previous round key.
  function automatic logic [127:0] nextRoundKey(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon(r), 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] roundKey(input logic [127:0] key, input int idx);
    logic [127:0] k;
    k = key;
    for (int i = 1; i <= idx; i++) k = nextRoundKey(k, 4'(i));
    return k;
  endfunction

  // Expansion stage: registered, bypass loads, enable expands, otherwise hold.
  // Its active-low asynchronous reset is driven from the inverted bench reset.
  wire stageRstN = ~reset;
  always @(posedge clock or negedge stageRstN) begin
    if (!stageRstN)    keKeyOut <= '0;
    else if (keBypass) keKeyOut <= keKeyIn;
    else if (keEnable) keKeyOut <= nextRoundKey(keKeyIn, keRound);
  end

  // Expected controller behaviour. mLeft counts the cycles of busy left after
  // an accepted start (12 on the start edge); the key set only becomes readable
  // once that count runs out. Reads see readiness from before the edge.
  int           mLeft = 0;
  bit           mReady = 1'b0;
  logic [127:0] mPending [0:10];
  logic [127:0] mKeys [0:10];
  bit           mValid = 1'b0;
  bit           mErr = 1'b0;
  logic [127:0] mKey = '0;

  always @(posedge clock) begin
    if (reset) begin
      mLeft  <= 0;
      mReady <= 1'b0;
      mValid <= 1'b0;
      mErr   <= 1'b0;
      mKey   <= '0;
    end else begin
      if (rdEn) begin
        if (mReady && rdRound <= 4'd10) begin
          mValid <= 1'b1;
          mErr   <= 1'b0;
          mKey   <= mKeys[rdRound];
        end else begin
          mValid <= 1'b0;
          mErr   <= 1'b1;
          mKey   <= '0;
        end
      end else begin
        mValid <= 1'b0;
        mErr   <= 1'b0;
      end
      if (mLeft > 0) begin
        mLeft <= mLeft - 1;
        if (mLeft == 1) begin
          mReady <= 1'b1;
          mKeys  <= mPending;
        end
      end else if (start) begin
        mLeft  <= 12;
        mReady <= 1'b0;
        for (int i = 0; i <= 10; i++) mPending[i] <= roundKey(cipherKey, i);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every cycle after reset, compare all controller outputs with the expectation.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("busy", 128'(busy), 128'(mLeft > 0));
      checkOutput("keys_ready", 128'(keysReady), 128'(mReady));
      checkOutput("ke_bypass", 128'(keBypass), 128'(mLeft == 12));
      checkOutput("ke_enable", 128'(keEnable), 128'(mLeft >= 2 && mLeft <= 11));
      checkOutput("ke_round", 128'(keRound), 128'((mLeft >= 2 && mLeft <= 11) ? 12 - mLeft : 0));
      checkOutput("ke_key_in", keKeyIn, (mLeft == 12) ? cipherKey : keKeyOut);
      checkOutput("bypass_and_enable", 128'(keBypass & keEnable), 128'(0));
      checkOutput("rd_valid", 128'(rdValid), 128'(mValid));
      checkOutput("rd_err", 128'(rdErr), 128'(mErr));
      checkOutput("rd_key", rdKey, mKey);
    end
  end

  // Drive one cycle of inputs, two time units after the rising edge.
  task automatic applyStimulus(input logic st, input logic [127:0] key, input logic en, input logic [3:0] rnd);
    @(posedge clock);
    #2;
    start     = st;
    cipherKey = key;
    rdEn      = en;
    rdRound   = rnd;
  endtask

  // Start a schedule, optionally re-pulse start at a later edge, and measure
  // the number of edges from the start edge until keys_ready is seen.
  task automatic runSchedule(input logic [127:0] key, input int pulseAt, input logic rdAtStart);
    int lat;
    applyStimulus(1'b1, key, rdAtStart, 4'd10);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(1'(e == pulseAt), key, 1'b0, 4'd0);
      if (e == 1) begin
        checkOutput("ready_low_after_start", 128'(keysReady), 128'(0));
        checkOutput("busy_after_start", 128'(busy), 128'(1));
      end
      if (keysReady) begin
        lat = e - 1;
        break;
      end
    end
    checkOutput("latency", 128'(lat), 128'(12));
  endtask

  // Single read followed by an idle cycle, checked against literals.
  task automatic readOne(input logic [3:0] rnd, input logic [127:0] expKey, input logic expValid, input logic expErr);
    applyStimulus(1'b0, cipherKey, 1'b1, rnd);
    applyStimulus(1'b0, cipherKey, 1'b0, 4'd0);
    checkOutput($sformatf("read%0d_valid", rnd), 128'(rdValid), 128'(expValid));
    checkOutput($sformatf("read%0d_err", rnd), 128'(rdErr), 128'(expErr));
    checkOutput($sformatf("read%0d_key", rnd), rdKey, expKey);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int validCount;
    // Reset values.
    @(posedge clock);
    #1;
    checkEn = 1'b1;
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_keys_ready", 128'(keysReady), 128'(0));
    checkOutput("reset_ke_enable", 128'(keEnable), 128'(0));
    checkOutput("reset_ke_bypass", 128'(keBypass), 128'(0));
    checkOutput("reset_ke_round", 128'(keRound), 128'(0));
    checkOutput("reset_rd_valid", 128'(rdValid), 128'(0));
    checkOutput("reset_rd_err", 128'(rdErr), 128'(0));
    checkOutput("reset_rd_key", rdKey, 128'(0));
    @(posedge clock);
    #2;
    reset = 1'b0;

    // Read before any keys exist.
    readOne(4'd3, 128'(0), 1'b0, 1'b1);

    // FIPS-197 schedule and literal round keys.
    runSchedule(FipsKey, 0, 1'b0);
    readOne(4'd0, FipsKey, 1'b1, 1'b0);
    readOne(4'd1, FipsR1, 1'b1, 1'b0);
    readOne(4'd10, FipsR10, 1'b1, 1'b0);

    // Back-to-back reverse-order reads.
    validCount = 0;
    for (int i = 0; i <= 11; i++) begin
      applyStimulus(1'b0, FipsKey, 1'(i < 11), (i < 11) ? 4'(10 - i) : 4'd0);
      if (i > 0 && rdValid) validCount++;
    end
    checkOutput("reverse_valid_count", 128'(validCount), 128'(11));

    // Out-of-range reads.
    readOne(4'd11, 128'(0), 1'b0, 1'b1);
    readOne(4'd15, 128'(0), 1'b0, 1'b1);

    // Restart from DONE with a start pulse during EXPAND round 5.
    runSchedule(FipsKey, 6, 1'b0);
    readOne(4'd10, FipsR10, 1'b1, 1'b0);

    // Reset during EXPAND round 7.
    applyStimulus(1'b1, FipsKey, 1'b0, 4'd0);
    repeat (8) applyStimulus(1'b0, FipsKey, 1'b0, 4'd0);
    checkOutput("pre_reset_ke_round", 128'(keRound), 128'(7));
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midreset_busy", 128'(busy), 128'(0));
    checkOutput("midreset_keys_ready", 128'(keysReady), 128'(0));
    checkOutput("midreset_ke_enable", 128'(keEnable), 128'(0));
    #1;
    reset = 1'b0;
    runSchedule(SeqKey, 0, 1'b0);
    readOne(4'd10, SeqR10, 1'b1, 1'b0);

    // Restart from DONE with a new key; the read on the start edge returns
    // the old round 10 key.
    applyStimulus(1'b1, FipsKey, 1'b1, 4'd10);
    applyStimulus(1'b0, FipsKey, 1'b0, 4'd0);
    checkOutput("restart_read_old_key", rdKey, SeqR10);
    checkOutput("restart_ready_low", 128'(keysReady), 128'(0));
    repeat (12) applyStimulus(1'b0, FipsKey, 1'b0, 4'd0);
    checkOutput("restart_ready_high", 128'(keysReady), 128'(1));
    readOne(4'd10, FipsR10, 1'b1, 1'b0);
    readOne(4'd0, FipsKey, 1'b1, 1'b0);

    // Restart once more through the latency-measuring path, reading at start.
    runSchedule(SeqKey, 0, 1'b1);
    readOne(4'd0, SeqKey, 1'b1, 1'b0);

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
